// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder computing a+b+cin one bit per clock,
// with a valid/ready handshake on both the operand and the result side.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sum_bit;
  logic               carry_nxt;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load on operand handshake, finish after the MSB, release on result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)          state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE: if (out_ready)         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: capture operands, then one full-adder bit per RUN cycle.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; result and carry hold their last values outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // After the last bit the result register holds the sum and the carry register the carry-out.
  assign sum  = res_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against a+b+cin.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // One operation from IDLE: handshake, wait for the result, stall, then release it.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input int stall);
    logic [W:0] exp;
    int n;
    int nb;
    exp = ref_add(ta, tb, tc);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tc;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n  = 0;
    nb = 0;
    while (out_valid !== 1'b1 && n < int'(W) + 4) begin
      if (busy === 1'b1) nb++;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(W));
    check("busy_cycles", 64'(nb), 64'(W));
    check("result", 64'({cout, sum}), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 64'({out_valid, in_ready, busy}), 64'(3'b100));
      check("stall_result", 64'({cout, sum}), 64'(exp));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_idle", 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  // Stream of operations scored through an expected-result queue.
  task automatic run_stream(input int n_ops, input bit stalls);
    logic [W:0] expq[$];
    logic [W:0] exp;
    logic [W:0] held;
    bit         stall_pending;
    int         issued;
    int         done;
    int         cyc;
    int         last_push;
    issued        = 0;
    done          = 0;
    cyc           = 0;
    last_push     = -1;
    stall_pending = 1'b0;
    held          = '0;
    while (done < n_ops && cyc < 40000) begin
      if (stall_pending) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_result", 64'({cout, sum}), 64'(held));
      end
      out_ready = stalls ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (issued < n_ops) begin
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready === 1'b1) begin
        expq.push_back(ref_add(a, b, cin));
        if (!stalls && last_push >= 0) check("b2b_gap", 64'(cyc - last_push), 64'(W + 2));
        last_push = cyc;
        issued++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        check("result_expected", 64'(expq.size() != 0), 64'(1));
        if (expq.size() != 0) begin
          exp = expq.pop_front();
          check("stream_result", 64'({cout, sum}), 64'(exp));
        end
        done++;
      end
      stall_pending = (out_valid === 1'b1) && !out_ready;
      held          = {cout, sum};
      tick();
      cyc++;
    end
    check("stream_done", 64'(done), 64'(n_ops));
    check("stream_drained", 64'(expq.size()), 64'(0));
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int ov;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'({out_valid, busy, cout, sum}), 64'(0));
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // Handshake on the first edge after reset release.
    do_op(8'h0F, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
    do_op(8'h00, 8'h00, 1'b0, 0);
    do_op(8'h5A, 8'h33, 1'b0, 5);

    // Reset four cycles into an operation.
    in_valid = 1'b1;
    a        = 8'hC3;
    b        = 8'h7E;
    cin      = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", 64'({out_valid, busy, cout, sum}), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("midrun_rst_in_ready", 64'(in_ready), 64'(1));
    ov = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) ov++;
      tick();
    end
    check("no_valid_after_rst", 64'(ov), 64'(0));
    do_op(8'h01, 8'h02, 1'b0, 0);

    // Back-to-back with in_valid held high and operands changing every cycle.
    run_stream(4, 1'b0);
    tick();
    check("b2b_idle", 64'(in_ready), 64'(1));

    // Random operands with random result stalls.
    run_stream(1000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/cin valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port a  input  WIDTH  addend A, sampled on input handshake.
REQ-007 SHALL have port b  input  WIDTH  addend B, sampled on input handshake.
REQ-008 SHALL have port cin  input  1  carry-in, sampled on input handshake.
REQ-009 SHALL have port out_valid  output  1  sum/cout hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  result bits of a+b+cin.
REQ-012 SHALL have port cout  output  1  carry-out of a+b+cin.
REQ-013 SHALL have port busy  output  1  high while in RUN state.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 only in RUN.
REQ-016 SHALL, in IDLE on clk edge with in_valid=1, load a and b into operand shift registers, load cin into the carry register, clear the bit counter, clear the result register, and enter RUN.
REQ-017 SHALL, each RUN cycle, form one full-adder bit from operand-A LSB, operand-B LSB and carry register: sum bit = XOR of the three, next carry = majority of the three.
REQ-018 SHALL, each RUN cycle, shift both operand registers right by one, shift the sum bit into the result register MSB (result shifts right), store next carry, increment the bit counter.
REQ-019 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, so out_valid rises exactly WIDTH cycles after the input-handshake edge.
REQ-020 SHALL present sum = (a+b+cin) mod 2^WIDTH and cout = bit WIDTH of a+b+cin, both held stable throughout DONE.
REQ-021 SHALL, in DONE on clk edge with out_ready=1, return to IDLE; with out_ready=0 remain in DONE indefinitely with outputs unchanged.
REQ-022 SHALL ignore in_valid outside IDLE and out_ready outside DONE; a, b and cin changes after the handshake SHALL not affect the result.
REQ-023 SHALL size the bit counter to $clog2(WIDTH) bits with no wrap before completion; throughput one result per WIDTH+2 cycles minimum.
REQ-024 SHALL hold sum and cout at last completed values in IDLE; they are only meaningful while out_valid=1.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, in_ready=1 (once rst deasserts, combinationally from state), out_valid=0, busy=0, sum=0, cout=0, counter, carry and operand registers to 0.
REQ-026 SHALL, on rst asserted mid-RUN or in DONE, discard the operation asynchronously; no out_valid pulse SHALL follow.
REQ-027 SHALL accept a new operand set on the first clk edge after rst deasserts if in_valid=1.

Verification (WIDTH=8)
REQ-028 SHALL cover: a=0x0F, b=0x01, cin=0, out_ready=1 -> out_valid exactly 8 cycles after handshake, sum=0x10, cout=0, busy high for 8 cycles.
REQ-029 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
REQ-030 SHALL cover backpressure: a=0x5A, b=0x33, out_ready=0 for 5 cycles after out_valid -> sum=0x8D, cout=0 stable, in_ready=0, then one-cycle out_ready -> IDLE next cycle.
REQ-031 SHALL cover reset mid-RUN: rst pulsed 4 cycles after handshake -> out_valid=0, in_ready=1, sum=0 immediately; next operands a=0x01, b=0x02 -> sum=0x03 after 8 cycles.
REQ-032 SHALL cover back-to-back: in_valid held high with operand changes during RUN, out_ready=1 -> second handshake on edge after DONE->IDLE, results match operands captured at each handshake only.
REQ-033 SHALL cover random check: 1000 random a/b/cin with random out_ready stalls -> every result equals reference a+b+cin, no lost or duplicated results.
